// File: rtl/speed_display_multi_if.sv
// Overlay-side bundle for the multi-digit speed display: pixel position, anchor,
// value/frame strobe in; foreground flag, busy and FSM state out.
interface speed_display_multi_if #(
   parameter int VAL_W = 10
);
   // Handshake: i_frame_start is a one-cycle strobe with no ready; it is accepted only
   // while o_busy=0 and dropped otherwise. o_valid is a per-pixel flag, not a transfer.
   logic             i_en;
   logic [12:0]      i_H_Cont;
   logic [12:0]      i_V_Cont;
   logic [12:0]      i_x;
   logic [12:0]      i_y;
   logic [VAL_W-1:0] i_value;
   logic             i_frame_start;
   logic             o_valid;
   logic             o_busy;
   logic [1:0]       o_dbg_state;

   modport master (
      output i_en, i_H_Cont, i_V_Cont, i_x, i_y, i_value, i_frame_start,
      input  o_valid, o_busy, o_dbg_state
   );

   modport slave (
      input  i_en, i_H_Cont, i_V_Cont, i_x, i_y, i_value, i_frame_start,
      output o_valid, o_busy, o_dbg_state
   );
endinterface

// File: rtl/speed_display_multi.sv
// Multi-digit 7-segment overlay: sequential double-dabble BCD conversion committed once
// per frame, and a 2-stage pixel pipeline that renders DIGITS glyphs at (i_x,i_y).
module speed_display_multi #(
   parameter int DIGITS   = 3,
   parameter int VAL_W    = 10,
   parameter int WIDTH    = 18,
   parameter int HEIGHT   = 30,
   parameter int GAP      = 4,
   parameter int LZ_BLANK = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   speed_display_multi_if.slave io_bus
);

   localparam int          CELL  = WIDTH + GAP;
   localparam int          SPAN  = DIGITS * CELL - GAP;
   localparam int          BCD_W = 4 * DIGITS;
   localparam int          K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int          COL_W = $clog2(CELL);
   localparam int          ROW_W = $clog2(HEIGHT);
   localparam int          CNT_W = $clog2(VAL_W + 1);
   localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);
   localparam int          T     = 3;
   localparam int          HM    = HEIGHT / 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t            r_state, w_next;
   logic              w_capture, w_step, w_commit, w_sat;
   logic [VAL_W-1:0]  r_shift, r_cap;
   logic [BCD_W-1:0]  r_bcd, r_disp, w_bcd_adj;
   logic [CNT_W-1:0]  r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_step    = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.i_frame_start) begin
               w_next    = S_CONV;
               w_capture = 1'b1;
            end
         end
         S_CONV: begin
            w_step = 1'b1;
            if (r_cnt == CNT_W'(VAL_W - 1)) w_next = S_COMMIT;
         end
         S_COMMIT: begin
            w_commit = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Only the low DIGITS nibbles are kept; higher BCD digits never feed back into them.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
   end

   assign w_sat = (32'(r_cap) >= LIMIT);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_shift <= '0;
         r_cap   <= '0;
         r_bcd   <= '0;
         r_disp  <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_capture) begin
            r_shift <= io_bus.i_value;
            r_cap   <= io_bus.i_value;
            r_bcd   <= '0;
            r_cnt   <= '0;
         end
         if (w_step) begin
            r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shift[VAL_W-1]};
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + CNT_W'(1);
         end
         if (w_commit) r_disp <= w_sat ? {DIGITS{4'h9}} : r_bcd;
      end
   end

   // Digit 0 is the most significant nibble; blanking runs left to right over zeros.
   logic [3:0]        w_dig [DIGITS];
   logic [DIGITS-1:0] w_blank;

   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         w_dig[k]   = r_disp[(DIGITS-1-k)*4 +: 4];
         zero_run   = zero_run & (w_dig[k] == 4'd0);
         w_blank[k] = (LZ_BLANK != 0) && zero_run && (k != DIGITS - 1);
      end
   end

   function automatic logic glyph_px(input logic [3:0] d, input logic [ROW_W-1:0] row,
                                     input logic [COL_W-1:0] col);
      logic [6:0] m;
      int         r, c;
      logic       mid, left, right, up, lo;
      case (d)
         4'd0:    m = 7'b1111110;
         4'd1:    m = 7'b0110000;
         4'd2:    m = 7'b1101101;
         4'd3:    m = 7'b1111001;
         4'd4:    m = 7'b0110011;
         4'd5:    m = 7'b1011011;
         4'd6:    m = 7'b1011111;
         4'd7:    m = 7'b1110000;
         4'd8:    m = 7'b1111111;
         4'd9:    m = 7'b1111011;
         default: m = 7'b0000000;
      endcase
      r     = int'(row);
      c     = int'(col);
      mid   = (c >= T) && (c < WIDTH - T);
      left  = (c < T);
      right = (c >= WIDTH - T) && (c < WIDTH);
      up    = (r >= T) && (r < HM - 1);
      lo    = (r >= HM + 1) && (r < HEIGHT - T);
      return (m[6] && (r < T) && mid) ||
             (m[5] && up && right) ||
             (m[4] && lo && right) ||
             (m[3] && (r >= HEIGHT - T) && (r < HEIGHT) && mid) ||
             (m[2] && lo && left) ||
             (m[1] && up && left) ||
             (m[0] && (r >= HM - 1) && (r < HM + 1) && mid);
   endfunction

   // Stage 1: signed offsets keep pixels left of / above the anchor out of range.
   logic signed [13:0] w_dx, w_dy;
   logic [K_W-1:0]     w_k;
   logic [COL_W-1:0]   w_col;
   logic               w_in;

   assign w_dx  = $signed({1'b0, io_bus.i_H_Cont}) - $signed({1'b0, io_bus.i_x});
   assign w_dy  = $signed({1'b0, io_bus.i_V_Cont}) - $signed({1'b0, io_bus.i_y});
   assign w_k   = K_W'(w_dx[12:0] / 13'(CELL));
   assign w_col = COL_W'(w_dx[12:0] % 13'(CELL));
   assign w_in  = !w_dx[13] && !w_dy[13] && (w_dy[12:0] < 13'(HEIGHT)) &&
                  (w_dx[12:0] < 13'(SPAN)) && (w_col < COL_W'(WIDTH));

   logic [K_W-1:0]   r_k;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_dy;
   logic             r_in, r_en, r_valid;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_k     <= '0;
         r_col   <= '0;
         r_dy    <= '0;
         r_in    <= 1'b0;
         r_en    <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_k     <= w_in ? w_k : '0;
         r_col   <= w_col;
         r_dy    <= w_dy[ROW_W-1:0];
         r_in    <= w_in;
         r_en    <= io_bus.i_en;
         r_valid <= r_en && r_in && glyph_px(w_dig[r_k], r_dy, r_col) && !w_blank[r_k];
      end
   end

   assign io_bus.o_valid     = r_valid;
   assign io_bus.o_busy      = (r_state != S_IDLE);
   assign io_bus.o_dbg_state = r_state;

endmodule
